// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder and its load extender.
//   state_t          responder FSM encoding
//   BE_*             legal byte-enable patterns
//   DM_DEPTH_WORDS   default RAM depth in 32-bit words
//   DM_ADDR_BASE     default byte address of word 0
//   be_is_legal()    byte-enable legality check
package dm_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] BE_B0  = 4'b0001;
  localparam logic [3:0] BE_B1  = 4'b0010;
  localparam logic [3:0] BE_B2  = 4'b0100;
  localparam logic [3:0] BE_B3  = 4'b1000;
  localparam logic [3:0] BE_HLO = 4'b0011;
  localparam logic [3:0] BE_HHI = 4'b1100;
  localparam logic [3:0] BE_W   = 4'b1111;

  localparam int unsigned DM_DEPTH_WORDS = 4096;
  localparam logic [31:0] DM_ADDR_BASE   = 32'h0000_0000;

  function automatic logic be_is_legal(input logic [3:0] be);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_HLO, BE_HHI, BE_W: be_is_legal = 1'b1;
      default:                                          be_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Request/response bus between the memory stage (master) and the data-memory
// responder (slave).
//   req_valid/req_ready    request handshake
//   req_we/addr/be/wdata/sext  request payload
//   resp_valid/resp_ready  response handshake
//   resp_data/resp_err     response payload
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        req_sext;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, req_sext, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, req_sext, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/dm_responder_load_ext.sv
// Load lane extractor: picks the byte/halfword/word selected by a byte enable
// out of a RAM word and sign- or zero-extends it. Also usable in writeback.
//   word        raw 32-bit RAM word
//   be          byte enable
//   sext        1 = sign extend, 0 = zero extend
//   data        extended load value (0 when be is illegal)
//   be_illegal  be is not one of the legal patterns
module dm_load_ext
  import dm_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [3:0]  be,
  input  logic        sext,
  output logic [31:0] data,
  output logic        be_illegal
);

  always_comb begin
    data       = '0;
    be_illegal = !be_is_legal(be);
    case (be)
      BE_B0:  data = {{24{sext & word[7]}},  word[7:0]};
      BE_B1:  data = {{24{sext & word[15]}}, word[15:8]};
      BE_B2:  data = {{24{sext & word[23]}}, word[23:16]};
      BE_B3:  data = {{24{sext & word[31]}}, word[31:24]};
      BE_HLO: data = {{16{sext & word[15]}}, word[15:0]};
      BE_HHI: data = {{16{sext & word[31]}}, word[31:16]};
      BE_W:   data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: word RAM behind a valid/ready request/response bus
// with a programmable wait-state count, byte-lane masked stores and extended
// loads. Illegal byte enables and out-of-range addresses answer with an error
// and leave the RAM untouched.
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    dm_responder_if slave port
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready for a request; acceptance latches all request fields
// ST_WAIT | counting wait states; commits on the cycle the counter is 1
// ST_RESP | response valid and held until resp_ready
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter logic [31:0] ADDR_BASE   = DM_ADDR_BASE,
  parameter int unsigned WAIT_CYCLES = 1  // 0..15
) (
  input logic         clk,
  input logic         reset,
  dm_responder_if.slave bus
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        lat_we, lat_sext;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_be;
  logic [31:0] resp_data_q;
  logic        resp_err_q;

  logic        src_we, src_sext;
  logic [31:0] src_addr, src_wdata;
  logic [3:0]  src_be;
  logic [31:0] offset;
  logic [IDX_W-1:0] idx;
  logic        addr_err, be_illegal, err;
  logic [31:0] ext_data;
  logic        accept, commit, mem_we;
  logic        unused_offset_lsb;

  assign accept = bus.req_valid && (state == ST_IDLE);

  // With zero wait states the commit happens on the acceptance edge, so the
  // live request fields are used instead of the (not yet loaded) latch.
  always_comb begin
    src_we    = lat_we;
    src_addr  = lat_addr;
    src_be    = lat_be;
    src_wdata = lat_wdata;
    src_sext  = lat_sext;
    if (state == ST_IDLE) begin
      src_we    = bus.req_we;
      src_addr  = bus.req_addr;
      src_be    = bus.req_be;
      src_wdata = bus.req_wdata;
      src_sext  = bus.req_sext;
    end
  end

  assign offset            = src_addr - ADDR_BASE;
  assign unused_offset_lsb = ^offset[1:0];
  assign idx               = offset[IDX_W+1:2];
  assign addr_err          = (src_addr < ADDR_BASE) ||
                             ({2'b00, offset[31:2]} >= 32'(DEPTH_WORDS));
  assign err               = be_illegal || addr_err;

  dm_load_ext u_load_ext (
    .word       (mem[idx]),
    .be         (src_be),
    .sext       (src_sext),
    .data       (ext_data),
    .be_illegal (be_illegal)
  );

  assign commit = (accept && (WAIT_INIT == 4'd0)) ||
                  ((state == ST_WAIT) && (cnt == 4'd1));
  assign mem_we = commit && src_we && !err;

  // RAM has no reset; the reset term only blocks a commit while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && reset) begin
      for (int k = 0; k < 4; k++) begin
        if (src_be[k]) mem[idx][8*k +: 8] <= src_wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = (WAIT_INIT == 4'd0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd1) state_nx = ST_RESP;
      ST_RESP: if (bus.resp_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_be      <= '0;
      lat_wdata   <= '0;
      lat_sext    <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_be    <= bus.req_be;
        lat_wdata <= bus.req_wdata;
        lat_sext  <= bus.req_sext;
        cnt       <= WAIT_INIT;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        resp_data_q <= (src_we || err) ? '0 : ext_data;
        resp_err_q  <= err;
      end else if ((state == ST_RESP) && bus.resp_ready) begin
        resp_data_q <= '0;
        resp_err_q  <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (WAIT_CYCLES=1, 4096 words).
module tb_dm_responder;

  localparam int BUDGET = 50;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  dm_responder_if bus();

  dm_responder #(
    .DEPTH_WORDS (4096),
    .ADDR_BASE   (32'h0000_0000),
    .WAIT_CYCLES (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Drives one request, scrambles the request fields after acceptance, waits
  // for the response and completes the handshake. lat counts cycles from the
  // acceptance edge to resp_valid.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input logic sext,
                        output logic [31:0] data, output logic err, output int lat);
    int n;
    data = 32'hxxxx_xxxx;
    err  = 1'bx;
    lat  = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_be    = be;
    bus.req_wdata = wdata;
    bus.req_sext  = sext;
    n = 0;
    while (!bus.req_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout addr=%h got req_ready=%b exp=1", addr, bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_addr  = 32'hFFFF_FFF0;
    bus.req_be    = 4'b0101;
    bus.req_wdata = 32'h5A5A_5A5A;
    bus.req_sext  = ~sext;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < BUDGET);
    if (!bus.resp_valid) begin
      total++; bad++;
      $display("FAIL resp_timeout addr=%h got resp_valid=0 exp=1", addr);
      return;
    end
    data = bus.resp_data;
    err  = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    total++; if (bus.resp_data !== 32'h0) begin bad++; $display("FAIL reset_resp_data got=%h exp=0", bus.resp_data); end
    total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%b exp=0", bus.resp_err); end
    reset = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] d; logic e; int lat;
    do_req(1'b1, 32'h10, 4'b1111, 32'h89AB_CDEF, 1'b0, d, e, lat);
    total++; if (e !== 1'b0 || d !== 32'h0) begin bad++; $display("FAIL word_store got err=%b data=%h exp err=0 data=0", e, d); end
    total++; if (lat !== 2) begin bad++; $display("FAIL word_store_latency got=%0d exp=2", lat); end
    do_req(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, d, e, lat);
    total++; if (e !== 1'b0 || d !== 32'h89AB_CDEF) begin bad++; $display("FAIL word_load got err=%b data=%h exp err=0 data=89abcdef", e, d); end
    total++; if (lat !== 2) begin bad++; $display("FAIL word_load_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_byte_loads();
    logic [3:0]  tbe  [5] = '{4'b1000, 4'b1000, 4'b0001, 4'b0100, 4'b0010};
    logic        tsx  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] texp [5] = '{32'hFFFF_FF89, 32'h0000_0089, 32'hFFFF_FFEF, 32'hFFFF_FFAB, 32'h0000_00CD};
    logic [31:0] d; logic e; int lat;
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, 32'h10, tbe[i], 32'h0, tsx[i], d, e, lat);
      total++;
      if (e !== 1'b0 || d !== texp[i]) begin
        bad++;
        $display("FAIL byte_load be=%b sext=%b got err=%b data=%h exp err=0 data=%h", tbe[i], tsx[i], e, d, texp[i]);
      end
    end
  endtask

  task automatic test_half_merge();
    logic [3:0]  tbe  [3] = '{4'b1111, 4'b0011, 4'b1100};
    logic        tsx  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] texp [3] = '{32'h1234_CDEF, 32'hFFFF_CDEF, 32'h0000_1234};
    logic [31:0] d; logic e; int lat;
    do_req(1'b1, 32'h10, 4'b1100, 32'h1234_0000, 1'b0, d, e, lat);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL half_store err got=%b exp=0", e); end
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 32'h10, tbe[i], 32'h0, tsx[i], d, e, lat);
      total++;
      if (e !== 1'b0 || d !== texp[i]) begin
        bad++;
        $display("FAIL half_load be=%b sext=%b got err=%b data=%h exp err=0 data=%h", tbe[i], tsx[i], e, d, texp[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int lat;
    do_req(1'b1, 32'h10, 4'b0101, 32'hFFFF_FFFF, 1'b0, d, e, lat);
    total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL err_be0101_store got err=%b data=%h exp err=1 data=0", e, d); end
    do_req(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, d, e, lat);
    total++; if (e !== 1'b0 || d !== 32'h1234_CDEF) begin bad++; $display("FAIL err_word_unchanged got err=%b data=%h exp err=0 data=1234cdef", e, d); end
    do_req(1'b0, 32'h10, 4'b0000, 32'h0, 1'b1, d, e, lat);
    total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL err_be0000_load got err=%b data=%h exp err=1 data=0", e, d); end
    do_req(1'b1, 32'h0, 4'b1111, 32'h1111_1111, 1'b0, d, e, lat);
    do_req(1'b1, 32'h4000, 4'b1111, 32'hDEAD_BEEF, 1'b0, d, e, lat);
    total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL err_range_store got err=%b data=%h exp err=1 data=0", e, d); end
    do_req(1'b0, 32'h4000, 4'b1111, 32'h0, 1'b0, d, e, lat);
    total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL err_range_load got err=%b data=%h exp err=1 data=0", e, d); end
    do_req(1'b0, 32'h0, 4'b1111, 32'h0, 1'b0, d, e, lat);
    total++; if (e !== 1'b0 || d !== 32'h1111_1111) begin bad++; $display("FAIL err_no_alias got err=%b data=%h exp err=0 data=11111111", e, d); end
    do_req(1'b1, 32'h3FFC, 4'b1111, 32'hA5A5_A5A5, 1'b0, d, e, lat);
    do_req(1'b0, 32'h3FFC, 4'b1111, 32'h0, 1'b0, d, e, lat);
    total++; if (e !== 1'b0 || d !== 32'hA5A5_A5A5) begin bad++; $display("FAIL last_word got err=%b data=%h exp err=0 data=a5a5a5a5", e, d); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic e; int lat; int n;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h10;
    bus.req_be = 4'b1111; bus.req_wdata = 32'h0; bus.req_sext = 1'b0;
    @(posedge clk);
    #1;
    // second request stays asserted from here on and must wait its turn
    bus.req_we = 1'b1; bus.req_wdata = 32'hCAFE_F00D;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.resp_valid && n < BUDGET);
    total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL bp_resp_timeout got resp_valid=%b exp=1", bus.resp_valid); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h1234_CDEF || bus.resp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got valid=%b data=%h err=%b req_ready=%b exp 1 1234cdef 0 0",
                 i, bus.resp_valid, bus.resp_data, bus.resp_err, bus.req_ready);
      end
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    total++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL bp_after_hs got valid=%b req_ready=%b exp 0 1", bus.resp_valid, bus.req_ready); end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL bp_second_accept got req_ready=%b exp=0", bus.req_ready); end
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.resp_valid && n < BUDGET);
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_data !== 32'h0) begin bad++; $display("FAIL bp_second_resp got valid=%b err=%b data=%h exp 1 0 0", bus.resp_valid, bus.resp_err, bus.resp_data); end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    do_req(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, d, e, lat);
    total++; if (e !== 1'b0 || d !== 32'hCAFE_F00D) begin bad++; $display("FAIL bp_second_store got err=%b data=%h exp err=0 data=cafef00d", e, d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int lat;
    do_req(1'b1, 32'h20, 4'b1111, 32'h0, 1'b0, d, e, lat);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20;
    bus.req_be = 4'b1111; bus.req_wdata = 32'h55AA_55AA; bus.req_sext = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_in_wait got req_ready=%b exp=0", bus.req_ready); end
    reset = 1'b0;
    #1;
    total++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0 || bus.resp_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_outputs got req_ready=%b valid=%b data=%h err=%b exp 1 0 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_data, bus.resp_err);
    end
    @(negedge clk);
    reset = 1'b1;
    do_req(1'b0, 32'h20, 4'b1111, 32'h0, 1'b0, d, e, lat);
    total++; if (e !== 1'b0 || d !== 32'h0) begin bad++; $display("FAIL rst_mid_discard got err=%b data=%h exp err=0 data=0", e, d); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_be     = '0;
    bus.req_wdata  = '0;
    bus.req_sext   = 1'b0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_word();
    test_byte_loads();
    test_half_merge();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
